// File: rtl/rx_nibble_packer.sv
// Packs received nibbles into NIB_PER_WORD-wide words, buffers them in a small
// first-word-fall-through FIFO and flags dropped words and broken increment sequences.
module rx_nibble_packer #(
  parameter int NIB_PER_WORD = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_b,
  input  logic                          rst_n,
  input  logic                          nib_valid,
  input  logic [3:0]                    nib_data,
  input  logic                          clr_flags,
  output logic                          word_valid,
  output logic [4*NIB_PER_WORD-1:0]     word_data,
  input  logic                          word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          seq_err,
  output logic [7:0]                    err_cnt
);
  localparam int W    = 4 * NIB_PER_WORD;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int IW   = (NIB_PER_WORD > 1) ? $clog2(NIB_PER_WORD) : 1;
  localparam int LVLW = AW + 1;

  logic [IW-1:0]                r_idx;
  logic [W-1:0]                 r_asm;
  logic [FIFO_DEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]                r_wr, r_rd;
  logic [LVLW-1:0]              r_level;
  logic                         r_ovf, r_serr, r_armed;
  logic [3:0]                   r_exp;
  logic [7:0]                   r_cnt;

  logic [W-1:0] w_word;
  logic         w_push, w_pop, w_full, w_wr, w_mis;

  // Completed word = assembly register with the arriving nibble merged in.
  always_comb begin
    w_word = r_asm;
    w_word[4*r_idx +: 4] = nib_data;
  end

  assign w_push = nib_valid && (r_idx == IW'(NIB_PER_WORD - 1));
  assign w_pop  = (r_level != '0) && word_ready;
  assign w_full = (r_level == LVLW'(FIFO_DEPTH));
  // A pop on a full FIFO frees the slot the push lands in.
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_mis  = nib_valid && r_armed && (nib_data != r_exp) && !clr_flags;

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_asm <= '0;
    end else if (nib_valid) begin
      r_asm <= w_word;
      r_idx <= w_push ? '0 : r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= w_word;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf   <= 1'b0;
      r_serr  <= 1'b0;
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_exp   <= '0;
    end else begin
      if (clr_flags) begin
        r_ovf  <= 1'b0;
        r_serr <= 1'b0;
        r_cnt  <= '0;
      end else begin
        if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
        if (w_mis) begin
          r_serr <= 1'b1;
          if (r_cnt != 8'hFF) r_cnt <= r_cnt + 1'b1;
        end
      end
      // Clear disarms, but a same-cycle nibble re-arms as a first nibble.
      if (nib_valid) begin
        r_exp   <= nib_data + 4'd1;
        r_armed <= 1'b1;
      end else if (clr_flags) begin
        r_armed <= 1'b0;
      end
    end
  end

  assign word_valid = (r_level != '0);
  assign word_data  = r_mem[r_rd];
  assign fifo_level = r_level;
  assign overflow   = r_ovf;
  assign seq_err    = r_serr;
  assign err_cnt    = r_cnt;
endmodule

// File: tb/tb_rx_nibble_packer.sv
// Randomized and directed bench for rx_nibble_packer, checked every cycle
// against a queue-based model of packing, FIFO and sequence rules.
module tb_rx_nibble_packer;
  localparam int N = 4;
  localparam int D = 4;
  localparam int W = 4 * N;

  logic          clk_b = 1'b0;
  logic          rst_n = 1'b0;
  logic          nib_valid = 1'b0;
  logic [3:0]    nib_data = '0;
  logic          clr_flags = 1'b0;
  logic          word_valid;
  logic [W-1:0]  word_data;
  logic          word_ready = 1'b0;
  logic [2:0]    fifo_level;
  logic          overflow, seq_err;
  logic [7:0]    err_cnt;

  int checks = 0;
  int errors = 0;

  rx_nibble_packer #(.NIB_PER_WORD(N), .FIFO_DEPTH(D)) dut (
    .clk_b(clk_b), .rst_n(rst_n), .nib_valid(nib_valid), .nib_data(nib_data),
    .clr_flags(clr_flags), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .fifo_level(fifo_level), .overflow(overflow),
    .seq_err(seq_err), .err_cnt(err_cnt)
  );

  always #5 clk_b = ~clk_b;

  // Behavioural model
  logic [W-1:0] mq[$];
  logic [W-1:0] m_acc;
  int           m_idx, m_cnt;
  bit           m_ovf, m_serr, m_armed;
  int           m_exp;

  always @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_acc = '0; m_idx = 0; m_cnt = 0;
      m_ovf = 0; m_serr = 0; m_armed = 0; m_exp = 0;
    end else begin
      if (mq.size() != 0 && word_ready) void'(mq.pop_front());
      if (nib_valid) begin
        m_acc = (m_idx == 0) ? W'(nib_data) : (m_acc | (W'(nib_data) << (4 * m_idx)));
        if (m_idx == N - 1) begin
          if (mq.size() < D) mq.push_back(m_acc);
          else m_ovf = 1;
          m_idx = 0;
        end else m_idx++;
      end
      if (clr_flags) begin
        m_ovf = 0; m_serr = 0; m_cnt = 0; m_armed = 0;
      end
      if (nib_valid) begin
        if (m_armed && int'(nib_data) != m_exp) begin
          m_serr = 1;
          if (m_cnt < 255) m_cnt++;
        end
        m_exp = (int'(nib_data) + 1) % 16;
        m_armed = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk_b) begin
    if (rst_n) begin
      chk("word_valid", 32'(word_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("word_data", 32'(word_data), 32'(mq[0]));
      chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("seq_err", 32'(seq_err), 32'(m_serr));
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
    end
  end

  task automatic cyc(input logic v, input logic [3:0] d, input logic rdy, input logic clr);
    @(posedge clk_b);
    #1;
    nib_valid = v; nib_data = d; word_ready = rdy; clr_flags = clr;
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_b);
    #2;
    rst_n = 1'b0;
    nib_valid = 0; word_ready = 0; clr_flags = 0; nib_data = 0;
    #1;
    chk("rst word_valid", 32'(word_valid), 32'd0);
    chk("rst word_data", 32'(word_data), 32'd0);
    chk("rst fifo_level", 32'(fifo_level), 32'd0);
    chk("rst flags", {29'd0, overflow, seq_err, 1'b0}, 32'd0);
    chk("rst err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk_b);
    rst_n = 1'b1;
  endtask

  logic [W-1:0] drain_exp[4];

  initial begin
    drain_exp[0] = 16'h3210; drain_exp[1] = 16'h7654;
    drain_exp[2] = 16'hBA98; drain_exp[3] = 16'hFEDC;
    #12;
    do_reset();

    // Basic packing
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
    idle();
    @(negedge clk_b);
    chk("t1 word_valid", 32'(word_valid), 32'd1);
    chk("t1 word_data", 32'(word_data), 32'h3210);
    chk("t1 level", 32'(fifo_level), 32'd1);
    chk("t1 seq_err", 32'(seq_err), 32'd0);

    // Overflow with F->0 wrap, then drain in order
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b1, 4'(i % 16), 1'b0, 1'b0);
    idle();
    @(negedge clk_b);
    chk("t2 overflow", 32'(overflow), 32'd1);
    chk("t2 level", 32'(fifo_level), 32'd4);
    chk("t2 seq_err", 32'(seq_err), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_b);
      chk("t2 drain", 32'(word_data), 32'(drain_exp[k]));
      cyc(1'b0, 4'h0, 1'b1, 1'b0);
      idle();
    end
    @(negedge clk_b);
    chk("t2 empty", 32'(word_valid), 32'd0);

    // Push and pop together while full
    do_reset();
    for (int i = 0; i < 19; i++) cyc(1'b1, 4'(i % 16), 1'b0, 1'b0);
    cyc(1'b1, 4'h3, 1'b1, 1'b0);
    idle();
    @(negedge clk_b);
    chk("t3 level", 32'(fifo_level), 32'd4);
    chk("t3 overflow", 32'(overflow), 32'd0);
    chk("t3 head", 32'(word_data), 32'h7654);

    // Sequence errors and clear
    do_reset();
    cyc(1'b1, 4'h1, 1'b1, 1'b0); cyc(1'b1, 4'h2, 1'b1, 1'b0);
    cyc(1'b1, 4'h5, 1'b1, 1'b0); cyc(1'b1, 4'h6, 1'b1, 1'b0);
    cyc(1'b1, 4'h9, 1'b1, 1'b0);
    idle();
    @(negedge clk_b);
    chk("t4 seq_err", 32'(seq_err), 32'd1);
    chk("t4 err_cnt", 32'(err_cnt), 32'd2);
    cyc(1'b1, 4'h3, 1'b1, 1'b1);
    idle();
    @(negedge clk_b);
    chk("t4 clr seq_err", 32'(seq_err), 32'd0);
    chk("t4 clr err_cnt", 32'(err_cnt), 32'd0);
    cyc(1'b1, 4'h4, 1'b1, 1'b0);
    idle();
    @(negedge clk_b);
    chk("t4 after 4", 32'(err_cnt), 32'd0);
    cyc(1'b1, 4'h7, 1'b1, 1'b0);
    idle();
    @(negedge clk_b);
    chk("t4 after 7", 32'(err_cnt), 32'd1);

    // Reset mid-word with buffered words
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
    idle();
    do_reset();
    cyc(1'b1, 4'h8, 1'b0, 1'b0); cyc(1'b1, 4'h9, 1'b0, 1'b0);
    cyc(1'b1, 4'hA, 1'b0, 1'b0); cyc(1'b1, 4'hB, 1'b0, 1'b0);
    idle();
    @(negedge clk_b);
    chk("t5 word", 32'(word_data), 32'hBA98);
    chk("t5 level", 32'(fifo_level), 32'd1);
    chk("t5 seq_err", 32'(seq_err), 32'd0);

    // err_cnt saturation
    do_reset();
    for (int i = 0; i < 300; i++) cyc(1'b1, 4'h5, 1'b1, 1'b0);
    idle();
    @(negedge clk_b);
    chk("sat err_cnt", 32'(err_cnt), 32'd255);

    // Randomized traffic
    do_reset();
    begin
      logic [3:0] nxt;
      nxt = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4000; i++) begin
        logic v, r, c;
        logic [3:0] d;
        v = ($urandom_range(0, 9) < 7);
        r = ($urandom_range(0, 9) < 4);
        c = ($urandom_range(0, 49) == 0);
        d = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : nxt;
        if (v) nxt = d + 4'd1;
        cyc(v, d, r, c);
        if ($urandom_range(0, 999) == 0) do_reset();
      end
    end
    idle();
    repeat (2) @(negedge clk_b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
